// File: rtl/nvio3_regfile.sv
// Multi-read-port register file with a zero-register alias and a self-clearing sweep.
// Reads are registered with write-first bypass; storage has no reset so it can map to block RAM.
module nvio3_regfile #(
  parameter int WID   = 128,
  parameter int AWID  = 13,
  parameter int NRD   = 3,
  parameter int ZBITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr,
  input  logic [AWID-1:0]     wadr,
  input  logic [WID-1:0]      i,
  input  logic [NRD*AWID-1:0] radr,
  output logic [NRD*WID-1:0]  o,
  output logic                rdy
);

  typedef enum logic { CLEAR, READY } state_t;
  typedef enum logic [1:0] { SEL_ZERO, SEL_RAM, SEL_BYP } sel_t;

  localparam logic [AWID-1:0] LAST_ADR = '1;

  state_t          state_q, state_d;
  logic [AWID-1:0] ccnt_q, ccnt_d;
  logic            rdy_q, rdy_d;

  logic            mem_we;
  logic [AWID-1:0] mem_wadr;
  logic [WID-1:0]  mem_wdata;
  logic [WID-1:0]  mem [2**AWID];

  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          ccnt_d = '0;
        end else if (ccnt_q == LAST_ADR) begin
          state_d = READY;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q + AWID'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          ccnt_d  = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ccnt_d  = '0;
      end
    endcase
    rdy_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ccnt_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy = rdy_q;

  // Single write port shared between the clear sweep and user writes; clr drops a user write.
  always_comb begin
    mem_we    = 1'b0;
    mem_wadr  = wadr;
    mem_wdata = i;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_wadr  = ccnt_q;
      mem_wdata = '0;
    end else if (wr && !clr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wadr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AWID-1:0] ra;
    logic [WID-1:0]  ram_q;
    logic [WID-1:0]  byp_q, byp_d;
    sel_t            sel_q, sel_d;

    assign ra    = radr[k*AWID +: AWID];
    assign byp_d = i;

    // Output forced to zero for the aliased zero register and for any cycle spent in or entering CLEAR.
    always_comb begin
      sel_d = SEL_RAM;
      if (state_q == CLEAR || state_d == CLEAR || ra[ZBITS-1:0] == '0) begin
        sel_d = SEL_ZERO;
      end else if (wr && wadr == ra) begin
        sel_d = SEL_BYP;
      end
    end

    always_ff @(posedge clk) begin
      ram_q <= mem[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel_q <= SEL_ZERO;
        byp_q <= '0;
      end else begin
        sel_q <= sel_d;
        byp_q <= byp_d;
      end
    end

    assign o[k*WID +: WID] = (sel_q == SEL_RAM) ? ram_q :
                             (sel_q == SEL_BYP) ? byp_q : '0;
  end

endmodule

// File: tb/tb_nvio3_regfile.sv
// Directed-vector bench for nvio3_regfile at default parameters (128-bit, 8192 entries, 3 read ports).
module tb_nvio3_regfile;

  localparam int WID  = 128;
  localparam int AWID = 13;
  localparam int NRD  = 3;
  localparam int SWEEP = 8192;

  logic                clk;
  logic                rst_n;
  logic                clr;
  logic                wr;
  logic [AWID-1:0]     wadr;
  logic [WID-1:0]      i;
  logic [NRD*AWID-1:0] radr;
  logic [NRD*WID-1:0]  o;
  logic                rdy;

  int vector_count;
  int miscompare_count;

  nvio3_regfile #(.WID(WID), .AWID(AWID), .NRD(NRD), .ZBITS(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .wr   (wr),
    .wadr (wadr),
    .i    (i),
    .radr (radr),
    .o    (o),
    .rdy  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WID-1:0] observed, input logic [WID-1:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [AWID-1:0] wa,
                               input logic [WID-1:0] d, input logic [AWID-1:0] r0,
                               input logic [AWID-1:0] r1, input logic [AWID-1:0] r2);
    clr  = c;
    wr   = w;
    wadr = wa;
    i    = d;
    radr = {r2, r1, r0};
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [WID-1:0] port(input int k);
    return o[k*WID +: WID];
  endfunction

  // Starts one cycle after the edge that zeroed ccnt; READY must arrive on exactly the 8192nd edge.
  task automatic sweepCheck(input string tag);
    tick(SWEEP - 1);
    checkOutput({tag, "_rdy_low_last"}, WID'(rdy), WID'(1'b0));
    checkOutput({tag, "_o0_clear"}, port(0), '0);
    tick(1);
    checkOutput({tag, "_rdy_high"}, WID'(rdy), WID'(1'b1));
  endtask

  initial begin
    logic [AWID-1:0] a0, a1, a2;
    vector_count     = 0;
    miscompare_count = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, '0);

    tick(3);
    checkOutput("reset_rdy", WID'(rdy), WID'(1'b0));
    checkOutput("reset_o", o[WID-1:0] | o[2*WID-1:WID] | o[3*WID-1:2*WID], '0);
    rst_n = 1'b1;
    sweepCheck("init");

    // Every entry reads zero after the initial sweep, three addresses per cycle.
    for (int a = 0; a < SWEEP; a += 3) begin
      a0 = AWID'(a);
      a1 = AWID'(a + 1);
      a2 = AWID'(a + 2);
      applyStimulus(1'b0, 1'b0, '0, '0, a0, a1, a2);
      tick(1);
      for (int k = 0; k < NRD; k++) checkOutput("init_zero", port(k), '0);
    end

    applyStimulus(1'b0, 1'b1, 13'h041, 128'hDEAD_BEEF, '0, '0, '0);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h041, '0, '0);
    tick(1);
    checkOutput("wr_rd_041", port(0), 128'hDEAD_BEEF);

    applyStimulus(1'b0, 1'b1, 13'h082, 128'h1234, 13'h041, 13'h082, 13'h082);
    tick(1);
    checkOutput("byp_p1", port(1), 128'h1234);
    checkOutput("byp_p2", port(2), 128'h1234);
    checkOutput("byp_p0_other", port(0), 128'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h041, 13'h082, 13'h082);
    tick(1);
    checkOutput("mem_082", port(1), 128'h1234);

    applyStimulus(1'b0, 1'b1, 13'h040, '1, 13'h040, 13'h040, 13'h040);
    tick(1);
    checkOutput("zero_byp", port(0), '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h040, 13'h040, 13'h040);
    tick(1);
    for (int k = 0; k < NRD; k++) checkOutput("zero_reg", port(k), '0);

    // clr sweep with a restart in the middle and user writes held active throughout.
    applyStimulus(1'b0, 1'b1, 13'h003, 128'h5555, 13'h003, 13'h041, 13'h082);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h003, 13'h041, 13'h082);
    tick(1);
    checkOutput("rd_003", port(0), 128'h5555);
    applyStimulus(1'b1, 1'b1, 13'h003, 128'hFFFF, 13'h003, 13'h041, 13'h082);
    tick(1);
    checkOutput("clr_rdy_low", WID'(rdy), WID'(1'b0));
    checkOutput("clr_o0", port(0), '0);
    checkOutput("clr_o1", port(1), '0);
    applyStimulus(1'b0, 1'b1, 13'h003, 128'hFFFF, 13'h003, 13'h041, 13'h082);
    tick(100);
    applyStimulus(1'b1, 1'b1, 13'h003, 128'hFFFF, 13'h003, 13'h041, 13'h082);
    tick(1);
    applyStimulus(1'b0, 1'b1, 13'h003, 128'hFFFF, 13'h003, 13'h041, 13'h082);
    sweepCheck("clr");
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h003, 13'h041, 13'h082);
    tick(1);
    checkOutput("clr_003", port(0), '0);
    checkOutput("clr_041", port(1), '0);
    checkOutput("clr_082", port(2), '0);

    // Asynchronous reset while READY with live nonzero output.
    applyStimulus(1'b0, 1'b1, 13'h041, 128'hDEAD_BEEF, '0, '0, '0);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h041, '0, '0);
    tick(1);
    checkOutput("pre_rst_041", port(0), 128'hDEAD_BEEF);
    checkOutput("pre_rst_rdy", WID'(rdy), WID'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_o0", port(0), '0);
    checkOutput("arst_rdy", WID'(rdy), WID'(1'b0));
    tick(2);
    rst_n = 1'b1;
    sweepCheck("rst_ready");
    tick(1);
    checkOutput("rst_041", port(0), '0);

    // Reset at ccnt = 100 of a sweep.
    applyStimulus(1'b1, 1'b0, '0, '0, 13'h041, '0, '0);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0, '0, 13'h041, '0, '0);
    tick(100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rdy", WID'(rdy), WID'(1'b0));
    checkOutput("mid_rst_o0", port(0), '0);
    tick(2);
    rst_n = 1'b1;
    sweepCheck("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
